// File: rtl/sync_ram_dp.sv
// True dual-port synchronous RAM with byte-lane writes, selectable read-during-write,
// optional second output register and a post-reset clear sequencer.
module sync_ram_dp #(
  parameter int ADDR_WIDTH   = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int BYTE_WIDTH   = 8,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic                             busy,
  input  logic                             a_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] a_we,
  input  logic [ADDR_WIDTH-1:0]            a_addr,
  input  logic [DATA_WIDTH-1:0]            a_din,
  output logic [DATA_WIDTH-1:0]            a_dout,
  output logic                             a_valid,
  input  logic                             b_en,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] b_we,
  input  logic [ADDR_WIDTH-1:0]            b_addr,
  input  logic [DATA_WIDTH-1:0]            b_din,
  output logic [DATA_WIDTH-1:0]            b_dout,
  output logic                             b_valid
);

  localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR = 1'b0, READY = 1'b1} state_e;

  function automatic logic [DATA_WIDTH-1:0] merge_lanes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [NB-1:0]         lanes
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (lanes[i]) res[i*BYTE_WIDTH +: BYTE_WIDTH] = new_word[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    return res;
  endfunction

  // Index 0 is port A, index 1 is port B.
  logic                  en   [2];
  logic [NB-1:0]         we   [2];
  logic [ADDR_WIDTH-1:0] addr [2];
  logic [DATA_WIDTH-1:0] din  [2];

  assign en[0]   = a_en;
  assign en[1]   = b_en;
  assign we[0]   = a_we;
  assign we[1]   = b_we;
  assign addr[0] = a_addr;
  assign addr[1] = b_addr;
  assign din[0]  = a_din;
  assign din[1]  = b_din;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic                  clr_we;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  acc       [2];
  logic [NB-1:0]         lane_we   [2];
  logic [DATA_WIDTH-1:0] rd_word   [2];
  logic [DATA_WIDTH-1:0] dout_p1_q [2];
  logic [DATA_WIDTH-1:0] dout_p1_d [2];
  logic [DATA_WIDTH-1:0] dout_p2_q [2];
  logic [DATA_WIDTH-1:0] dout_p2_d [2];
  logic                  vld_p1_q  [2];
  logic                  vld_p1_d  [2];
  logic                  vld_p2_q  [2];
  logic                  vld_p2_d  [2];

  assign busy = rst || (state_q == CLEAR);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    case (state_q)
      CLEAR: begin
        clr_we    = !rst;
        clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
        if (clr_cnt_q == '1) state_d = READY;
      end
      default: state_d = READY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Cross-port reads always see the pre-write word; write-first only merges the port's own lanes.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc[p]       = en[p] && !busy;
      lane_we[p]   = acc[p] ? we[p] : '0;
      rd_word[p]   = mem_q[addr[p]];
      if (RDW_MODE == 1) rd_word[p] = merge_lanes(mem_q[addr[p]], din[p], lane_we[p]);
      vld_p1_d[p]  = acc[p];
      dout_p1_d[p] = acc[p] ? rd_word[p] : dout_p1_q[p];
      vld_p2_d[p]  = vld_p1_q[p];
      dout_p2_d[p] = dout_p1_q[p];
    end
  end

  // Port B is applied first so port A wins on overlapping lanes.
  always_ff @(posedge clk) begin
    if (clr_we) mem_q[clr_cnt_q] <= INIT_VALUE;
    for (int p = 1; p >= 0; p--) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_we[p][i])
          mem_q[addr[p]][i*BYTE_WIDTH +: BYTE_WIDTH] <= din[p][i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  // Stage p1: array read; stage p2: optional extra output register.
  always_ff @(posedge clk) begin
    for (int p = 0; p < 2; p++) begin
      if (rst) begin
        vld_p1_q[p]  <= 1'b0;
        vld_p2_q[p]  <= 1'b0;
        dout_p1_q[p] <= '0;
        dout_p2_q[p] <= '0;
      end else begin
        vld_p1_q[p]  <= vld_p1_d[p];
        vld_p2_q[p]  <= vld_p2_d[p];
        dout_p1_q[p] <= dout_p1_d[p];
        dout_p2_q[p] <= dout_p2_d[p];
      end
    end
  end

  assign a_dout  = (READ_LATENCY == 2) ? dout_p2_q[0] : dout_p1_q[0];
  assign a_valid = (READ_LATENCY == 2) ? vld_p2_q[0]  : vld_p1_q[0];
  assign b_dout  = (READ_LATENCY == 2) ? dout_p2_q[1] : dout_p1_q[1];
  assign b_valid = (READ_LATENCY == 2) ? vld_p2_q[1]  : vld_p1_q[1];

endmodule

// File: tb/tb_sync_ram_dp.sv
// Bench for sync_ram_dp: instance 0 uses defaults (8-bit, latency 1, read-first),
// instance 1 is 32-bit with byte lanes, latency 2 and write-first.
module tb_sync_ram_dp;

  logic        clk;
  logic        rst;
  logic        en_a [2];
  logic        en_b [2];
  logic [3:0]  we_a [2];
  logic [3:0]  we_b [2];
  logic [3:0]  ad_a [2];
  logic [3:0]  ad_b [2];
  logic [31:0] di_a [2];
  logic [31:0] di_b [2];

  logic        busy0, busy1, va0, vb0, va1, vb1;
  logic [7:0]  da0, db0;
  logic [31:0] da1, db1;

  logic        busy_s  [2];
  logic        vld_a   [2];
  logic        vld_b   [2];
  logic [31:0] dout_a  [2];
  logic [31:0] dout_b  [2];

  assign busy_s[0] = busy0;
  assign busy_s[1] = busy1;
  assign vld_a[0]  = va0;
  assign vld_a[1]  = va1;
  assign vld_b[0]  = vb0;
  assign vld_b[1]  = vb1;
  assign dout_a[0] = {24'h0, da0};
  assign dout_a[1] = da1;
  assign dout_b[0] = {24'h0, db0};
  assign dout_b[1] = db1;

  sync_ram_dp u_dut0 (
    .clk(clk), .rst(rst), .busy(busy0),
    .a_en(en_a[0]), .a_we(we_a[0][0:0]), .a_addr(ad_a[0]), .a_din(di_a[0][7:0]),
    .a_dout(da0), .a_valid(va0),
    .b_en(en_b[0]), .b_we(we_b[0][0:0]), .b_addr(ad_b[0]), .b_din(di_b[0][7:0]),
    .b_dout(db0), .b_valid(vb0)
  );

  sync_ram_dp #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .BYTE_WIDTH(8), .READ_LATENCY(2),
                .RDW_MODE(1), .INIT_VALUE(32'h0)) u_dut1 (
    .clk(clk), .rst(rst), .busy(busy1),
    .a_en(en_a[1]), .a_we(we_a[1]), .a_addr(ad_a[1]), .a_din(di_a[1]),
    .a_dout(da1), .a_valid(va1),
    .b_en(en_b[1]), .b_we(we_b[1]), .b_addr(ad_b[1]), .b_din(di_b[1]),
    .b_dout(db1), .b_valid(vb1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mm [2][16];
  int          clr_left = 16;
  logic        held_a [2], held_b [2];
  logic [31:0] hd_a [2], hd_b [2];
  logic        pv_a [2], pv_b [2];
  logic [31:0] pd_a [2], pd_b [2];
  logic        ev_a [2], ev_b [2];
  logic [31:0] ed_a [2], ed_b [2];

  function automatic int nb_of(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] lanes, input int nb);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < nb; l++) if (lanes[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    for (int i = 0; i < 2; i++) begin
      en_a[i] = 1'b0; we_a[i] = 4'h0; ad_a[i] = 4'h0; di_a[i] = 32'h0;
      en_b[i] = 1'b0; we_b[i] = 4'h0; ad_b[i] = 4'h0; di_b[i] = 32'h0;
    end
  endtask

  // One clock of stimulus, advancing the model and comparing every output.
  task automatic step();
    logic        bp;
    logic        acc_a [2], acc_b [2];
    logic [31:0] ra [2], rb [2];
    bp = rst || (clr_left > 0);
    for (int i = 0; i < 2; i++) begin
      acc_a[i] = en_a[i] && !bp;
      acc_b[i] = en_b[i] && !bp;
      ra[i] = (i == 1) ? merge(mm[i][ad_a[i]], di_a[i], we_a[i], nb_of(i)) : mm[i][ad_a[i]];
      rb[i] = (i == 1) ? merge(mm[i][ad_b[i]], di_b[i], we_b[i], nb_of(i)) : mm[i][ad_b[i]];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (acc_b[i]) mm[i][ad_b[i]] = merge(mm[i][ad_b[i]], di_b[i], we_b[i], nb_of(i));
      if (acc_a[i]) mm[i][ad_a[i]] = merge(mm[i][ad_a[i]], di_a[i], we_a[i], nb_of(i));
    end
    if (rst) clr_left = 16;
    else if (clr_left > 0) begin
      clr_left--;
      if (clr_left == 0)
        for (int i = 0; i < 2; i++) for (int w = 0; w < 16; w++) mm[i][w] = 32'h0;
    end
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        hd_a[i] = 0; hd_b[i] = 0; pv_a[i] = 0; pv_b[i] = 0; pd_a[i] = 0; pd_b[i] = 0;
        ev_a[i] = 0; ev_b[i] = 0; ed_a[i] = 0; ed_b[i] = 0;
      end else begin
        if (acc_a[i]) hd_a[i] = ra[i];
        if (acc_b[i]) hd_b[i] = rb[i];
        held_a[i] = acc_a[i];
        held_b[i] = acc_b[i];
        if (lat_of(i) == 1) begin
          ev_a[i] = held_a[i]; ed_a[i] = hd_a[i]; ev_b[i] = held_b[i]; ed_b[i] = hd_b[i];
        end else begin
          ev_a[i] = pv_a[i]; ed_a[i] = pd_a[i]; ev_b[i] = pv_b[i]; ed_b[i] = pd_b[i];
        end
        pv_a[i] = held_a[i]; pd_a[i] = hd_a[i]; pv_b[i] = held_b[i]; pd_b[i] = hd_b[i];
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("m%0d_busy", i), {31'h0, busy_s[i]}, {31'h0, rst || (clr_left > 0)});
      chk($sformatf("m%0d_a_valid", i), {31'h0, vld_a[i]}, {31'h0, ev_a[i]});
      chk($sformatf("m%0d_b_valid", i), {31'h0, vld_b[i]}, {31'h0, ev_b[i]});
      chk($sformatf("m%0d_a_dout", i), dout_a[i], ed_a[i]);
      chk($sformatf("m%0d_b_dout", i), dout_b[i], ed_b[i]);
    end
  endtask

  typedef struct {
    int          inst;
    logic        ae; logic [3:0] awe; logic [3:0] aad; logic [31:0] adi;
    logic        be; logic [3:0] bwe; logic [3:0] bad; logic [31:0] bdi;
    logic        ca; logic [31:0] ea;
    logic        cb; logic [31:0] eb;
  } vec_t;

  function automatic vec_t mk(input int inst,
    input logic ae, input logic [3:0] awe, input logic [3:0] aad, input logic [31:0] adi,
    input logic be, input logic [3:0] bwe, input logic [3:0] bad, input logic [31:0] bdi,
    input logic ca, input logic [31:0] ea, input logic cb, input logic [31:0] eb);
    vec_t v;
    v.inst = inst;
    v.ae = ae; v.awe = awe; v.aad = aad; v.adi = adi;
    v.be = be; v.bwe = bwe; v.bad = bad; v.bdi = bdi;
    v.ca = ca; v.ea = ea; v.cb = cb; v.eb = eb;
    return v;
  endfunction

  vec_t tbl [15];

  initial begin
    int   n;
    logic seen;

    tbl[0]  = mk(0, 1, 4'h1, 4'd3, 32'h55,       0, 4'h0, 4'd0, 32'h0,  0, 32'h0,        0, 32'h0);
    tbl[1]  = mk(0, 1, 4'h0, 4'd3, 32'h0,        0, 4'h0, 4'd0, 32'h0,  1, 32'h55,       0, 32'h0);
    tbl[2]  = mk(0, 1, 4'h1, 4'd7, 32'h10,       0, 4'h0, 4'd0, 32'h0,  0, 32'h0,        0, 32'h0);
    tbl[3]  = mk(0, 1, 4'h1, 4'd7, 32'h20,       1, 4'h0, 4'd7, 32'h0,  1, 32'h10,       1, 32'h10);
    tbl[4]  = mk(0, 1, 4'h1, 4'd9, 32'hA1,       1, 4'h1, 4'd9, 32'hB2, 0, 32'h0,        0, 32'h0);
    tbl[5]  = mk(0, 1, 4'h0, 4'd9, 32'h0,        0, 4'h0, 4'd0, 32'h0,  1, 32'hA1,       0, 32'h0);
    tbl[6]  = mk(1, 1, 4'hF, 4'd3, 32'h55,       0, 4'h0, 4'd0, 32'h0,  0, 32'h0,        0, 32'h0);
    tbl[7]  = mk(1, 1, 4'h0, 4'd3, 32'h0,        0, 4'h0, 4'd0, 32'h0,  1, 32'h55,       0, 32'h0);
    tbl[8]  = mk(1, 1, 4'hF, 4'd5, 32'hAABBCCDD, 0, 4'h0, 4'd0, 32'h0,  0, 32'h0,        0, 32'h0);
    tbl[9]  = mk(1, 1, 4'h5, 4'd5, 32'h11223344, 0, 4'h0, 4'd0, 32'h0,  1, 32'hAA22CC44, 0, 32'h0);
    tbl[10] = mk(1, 0, 4'h0, 4'd0, 32'h0,        1, 4'h0, 4'd5, 32'h0,  0, 32'h0,        1, 32'hAA22CC44);
    tbl[11] = mk(1, 1, 4'hF, 4'd7, 32'h10,       0, 4'h0, 4'd0, 32'h0,  0, 32'h0,        0, 32'h0);
    tbl[12] = mk(1, 1, 4'hF, 4'd7, 32'h20,       1, 4'h0, 4'd7, 32'h0,  1, 32'h20,       1, 32'h10);
    tbl[13] = mk(1, 1, 4'hF, 4'd9, 32'hA1,       1, 4'hF, 4'd9, 32'hB2, 0, 32'h0,        0, 32'h0);
    tbl[14] = mk(1, 0, 4'h0, 4'd0, 32'h0,        1, 4'h0, 4'd9, 32'h0,  0, 32'h0,        1, 32'hA1);

    // Clear sequence length and initial contents
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (busy0 && n < 40);
    chk("clear_cycles", n, 16);
    for (int k = 0; k < 16; k++) begin
      en_a[0] = 1'b1; ad_a[0] = 4'(k);
      step();
      chk($sformatf("clear_rd_valid_%0d", k), {31'h0, va0}, 32'h1);
      chk($sformatf("clear_rd_data_%0d", k), {24'h0, da0}, 32'h0);
    end
    idle();

    // Directed vectors
    for (int k = 0; k < 15; k++) begin
      int i;
      i = tbl[k].inst;
      idle();
      en_a[i] = tbl[k].ae; we_a[i] = tbl[k].awe; ad_a[i] = tbl[k].aad; di_a[i] = tbl[k].adi;
      en_b[i] = tbl[k].be; we_b[i] = tbl[k].bwe; ad_b[i] = tbl[k].bad; di_b[i] = tbl[k].bdi;
      step();
      idle();
      for (int j = 1; j < lat_of(i); j++) step();
      if (tbl[k].ca) chk($sformatf("vec%0d_a_dout", k), dout_a[i], tbl[k].ea);
      if (tbl[k].cb) chk($sformatf("vec%0d_b_dout", k), dout_b[i], tbl[k].eb);
    end

    // Reset mid-clear with a write attempted throughout the busy window
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) step();
    rst = 1'b1;
    en_a[0] = 1'b1; we_a[0] = 4'h1; ad_a[0] = 4'd2; di_a[0] = 32'hFF;
    step();
    rst = 1'b0;
    n = 0;
    seen = 1'b0;
    do begin
      step();
      n++;
      if (va0) seen = 1'b1;
    end while (busy0 && n < 40);
    chk("restart_clear_cycles", n, 16);
    chk("valid_during_busy", {31'h0, seen}, 32'h0);
    idle();
    en_a[0] = 1'b1; ad_a[0] = 4'd2;
    step();
    chk("busy_write_ignored", {24'h0, da0}, 32'h0);
    idle();

    // Randomized traffic against the model, with one reset in the middle
    for (int c = 0; c < 400; c++) begin
      rst = (c == 200);
      for (int i = 0; i < 2; i++) begin
        en_a[i] = ($urandom_range(0, 3) != 0);
        en_b[i] = ($urandom_range(0, 3) != 0);
        we_a[i] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        we_b[i] = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
        ad_a[i] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        ad_b[i] = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
        di_a[i] = $urandom;
        di_b[i] = $urandom;
      end
      step();
    end
    rst = 1'b0;
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
